obi_uart_register_mc: RTL and testbench

Multi-channel successor of the single-UART register file. Serves NumChannels independent 16550-style register banks behind one OBI subordinate port. Adds OBI rready back-pressure with a one-entry response buffer, and a functional scratch register (SPR). Sits between the OBI crossbar and NumChannels UART TX/RX/modem cores; each core sees the same reg_read_t/reg_write_t bundle as the single-channel version.

---
 rtl/obi_uart_pkg.sv | 112 +++++++++++
 rtl/obi_uart_reg_bank.sv | 120 ++++++++++++
 rtl/obi_uart_register_mc.sv | 93 +++++++++
 tb/tb_obi_uart_register_mc.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_uart_pkg.sv
// Shared types for the multi-channel OBI UART register file.
// Register map, OBI bundles, per-channel register/update structs.
package obi_uart_pkg;

    localparam int unsigned DataWidth     = 32;
    localparam int unsigned AddrWidth     = 32;
    localparam int unsigned IdWidth       = 4;
    localparam int unsigned RegWidth      = 8;
    localparam int unsigned AddressOffset = 2;
    localparam int unsigned AddressBits   = 3;
    localparam int unsigned MaxChannels   = 16;
    localparam int unsigned ChanIdxBits   = $clog2(MaxChannels);

    typedef logic [AddressBits-1:0] reg_idx_t;
    typedef logic [ChanIdxBits-1:0] chan_idx_t;
    typedef logic [RegWidth-1:0]    reg_t;

    // DLAB=1 aliases DLL/DLM onto the RHR/IER slots; FCR is write-side of ISR
    localparam reg_idx_t RegAddrRHR = 3'd0;
    localparam reg_idx_t RegAddrTHR = 3'd0;
    localparam reg_idx_t RegAddrDLL = 3'd0;
    localparam reg_idx_t RegAddrIER = 3'd1;
    localparam reg_idx_t RegAddrDLM = 3'd1;
    localparam reg_idx_t RegAddrISR = 3'd2;
    localparam reg_idx_t RegAddrFCR = 3'd2;
    localparam reg_idx_t RegAddrLCR = 3'd3;
    localparam reg_idx_t RegAddrMCR = 3'd4;
    localparam reg_idx_t RegAddrLSR = 3'd5;
    localparam reg_idx_t RegAddrMSR = 3'd6;
    localparam reg_idx_t RegAddrSPR = 3'd7;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } obi_uart_rsp_buf_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        obi_uart_rsp_buf_t r;
    } obi_rsp_t;

    typedef struct packed {
        reg_t rhr;
        reg_t thr;
        reg_t ier;
        reg_t fcr;
        reg_t lcr;
        reg_t mcr;
        reg_t lsr;
        reg_t msr;
        reg_t spr;
        reg_t dll;
        reg_t dlm;
    } uart_reg_fields_t;

    typedef struct packed {
        uart_reg_fields_t regs;
        logic             obi_write_thr;
        logic             obi_write_dllm;
        logic             obi_read_rhr;
        logic             obi_read_isr;
        logic             obi_read_lsr;
        logic             obi_read_msr;
    } reg_read_t;

    typedef struct packed {
        logic valid;
        reg_t data;
    } reg_upd_t;

    typedef struct packed {
        logic valid;
        logic cts;
        logic dsr;
        logic ri;
        logic dcd;
        logic d_cts;
        logic d_dsr;
        logic d_ri;
        logic d_dcd;
    } modem_t;

    typedef struct packed {
        reg_upd_t rx;
        reg_upd_t lsr;
        reg_t     isr;
        modem_t   modem;
    } reg_write_t;

    localparam uart_reg_fields_t RegResetVal = '{
        rhr: 8'h00, thr: 8'h00, ier: 8'h00, fcr: 8'h00,
        lcr: 8'h00, mcr: 8'h00, lsr: 8'h60, msr: 8'h00,
        spr: 8'h00, dll: 8'h00, dlm: 8'h00
    };

endpackage

// File: rtl/obi_uart_reg_bank.sv
// One UART register bank: HW update merge, SW decode and access pulses.
// Read data and pulses are combinational for the grant cycle.
module obi_uart_reg_bank
    import obi_uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sel,
    input  logic       we,
    input  logic       be0,
    input  reg_idx_t   idx,
    input  reg_t       wdata,
    input  reg_write_t hw,
    output reg_t       rdata,
    output logic       err,
    output reg_read_t  reg_read
);

    uart_reg_fields_t q;
    uart_reg_fields_t d;
    logic             dlab;
    logic             wr;
    logic             rd;
    logic [3:0]       d_evt;

    assign dlab  = q.lcr[7];
    assign wr    = sel & we & be0;
    assign rd    = sel & ~we;
    assign d_evt = {hw.modem.d_dcd, hw.modem.d_ri, hw.modem.d_dsr, hw.modem.d_cts};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q <= RegResetVal;
        else       q <= d;
    end

    always_comb begin
        d             = q;
        rdata         = '0;
        err           = 1'b0;
        reg_read      = '0;
        reg_read.regs = q;

        if (hw.rx.valid)    d.rhr      = hw.rx.data;
        if (hw.lsr.valid)   d.lsr      = hw.lsr.data;
        if (hw.modem.valid) d.msr[7:4] = {hw.modem.dcd, hw.modem.ri, hw.modem.dsr, hw.modem.cts};
        d.msr[3:0] = q.msr[3:0] | d_evt;

        // SW write is applied after HW merge so it takes priority
        if (wr) begin
            case (idx)
                RegAddrTHR: begin
                    if (dlab) begin
                        d.dll                   = wdata;
                        reg_read.obi_write_dllm = 1'b1;
                    end else begin
                        d.thr                  = wdata;
                        reg_read.obi_write_thr = 1'b1;
                    end
                end
                RegAddrIER: begin
                    if (dlab) begin
                        d.dlm                   = wdata;
                        reg_read.obi_write_dllm = 1'b1;
                    end else begin
                        d.ier = wdata;
                    end
                end
                RegAddrFCR: d.fcr = wdata;
                RegAddrLCR: d.lcr = wdata;
                RegAddrMCR: d.mcr = wdata;
                RegAddrSPR: d.spr = wdata;
                default:    err   = 1'b1;
            endcase
        end

        if (rd) begin
            case (idx)
                RegAddrRHR: begin
                    if (dlab) begin
                        rdata = q.dll;
                    end else begin
                        rdata                 = q.rhr;
                        reg_read.obi_read_rhr = 1'b1;
                    end
                end
                RegAddrIER: rdata = dlab ? q.dlm : q.ier;
                RegAddrISR: begin
                    if (dlab) begin
                        err = 1'b1;
                    end else begin
                        rdata                 = hw.isr;
                        reg_read.obi_read_isr = 1'b1;
                    end
                end
                RegAddrLCR: rdata = q.lcr;
                RegAddrMCR: rdata = q.mcr;
                RegAddrLSR: begin
                    if (dlab) begin
                        err = 1'b1;
                    end else begin
                        rdata                 = q.lsr;
                        reg_read.obi_read_lsr = 1'b1;
                    end
                end
                RegAddrMSR: begin
                    if (dlab) begin
                        err = 1'b1;
                    end else begin
                        rdata                 = q.msr;
                        reg_read.obi_read_msr = 1'b1;
                        // clear sticky deltas but keep an event arriving now
                        d.msr[3:0]            = d_evt;
                    end
                end
                default:    rdata = q.spr;
            endcase
        end
    end

endmodule

// File: rtl/obi_uart_register_mc.sv
// Multi-channel OBI UART register file: channel decode, grant
// and a one-entry response buffer with rready back-pressure.
module obi_uart_register_mc
    import obi_uart_pkg::*;
#(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned ChanStride  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  obi_req_t                     obi_req_i,
    output obi_rsp_t                     obi_rsp_o,
    output reg_read_t  [NumChannels-1:0] reg_read_o,
    input  reg_write_t [NumChannels-1:0] reg_write_i
);

    localparam int unsigned ChanShift = $clog2(ChanStride);

    chan_idx_t                     chan;
    reg_idx_t                      idx;
    logic                          chan_ok;
    logic                          gnt;
    logic                          valid_q;
    obi_uart_rsp_buf_t             buf_q;
    obi_uart_rsp_buf_t             buf_d;
    logic [NumChannels-1:0]        sel;
    reg_t [NumChannels-1:0]        bank_rdata;
    logic [NumChannels-1:0]        bank_err;
    reg_t                          rd_sel;
    logic                          err_sel;
    logic                          unused_bits;

    // full MaxChannels-wide decode so addresses past NumChannels error out
    assign chan    = obi_req_i.a.addr[ChanShift +: ChanIdxBits];
    assign idx     = obi_req_i.a.addr[AddressOffset +: AddressBits];
    assign chan_ok = 32'(chan) < NumChannels;
    assign gnt     = obi_req_i.req & (~valid_q | obi_req_i.rready);

    assign unused_bits = ^{obi_req_i.a.addr, obi_req_i.a.be[DataWidth/8-1:1],
                           obi_req_i.a.wdata[DataWidth-1:RegWidth]};

    for (genvar c = 0; c < NumChannels; c++) begin : g_bank
        assign sel[c] = gnt & ~rst_i & chan_ok & (chan == chan_idx_t'(c));

        obi_uart_reg_bank u_bank (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .sel      (sel[c]),
            .we       (obi_req_i.a.we),
            .be0      (obi_req_i.a.be[0]),
            .idx      (idx),
            .wdata    (obi_req_i.a.wdata[RegWidth-1:0]),
            .hw       (reg_write_i[c]),
            .rdata    (bank_rdata[c]),
            .err      (bank_err[c]),
            .reg_read (reg_read_o[c])
        );
    end

    always_comb begin
        rd_sel  = '0;
        err_sel = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            if (chan == chan_idx_t'(c)) begin
                rd_sel  = bank_rdata[c];
                err_sel = bank_err[c];
            end
        end
    end

    always_comb begin
        buf_d.rid   = obi_req_i.a.aid;
        buf_d.err   = ~chan_ok | err_sel;
        buf_d.rdata = buf_d.err ? '0 : {{(DataWidth-RegWidth){1'b0}}, rd_sel};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            buf_q   <= '0;
        end else if (gnt) begin
            valid_q <= 1'b1;
            buf_q   <= buf_d;
        end else if (obi_req_i.rready) begin
            valid_q <= 1'b0;
        end
    end

    assign obi_rsp_o.gnt    = gnt;
    assign obi_rsp_o.rvalid = valid_q;
    assign obi_rsp_o.r      = buf_q;

endmodule

// File: tb/tb_obi_uart_register_mc.sv
// Scoreboard bench for obi_uart_register_mc against a name-level register model.
module tb_obi_uart_register_mc;
    import obi_uart_pkg::*;

    localparam int NCH    = 4;
    localparam int STRIDE = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    obi_req_t               req;
    obi_rsp_t               rsp;
    reg_read_t  [NCH-1:0]   rr;
    reg_write_t [NCH-1:0]   hw;

    obi_uart_register_mc #(.NumChannels(NCH), .ChanStride(STRIDE)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .obi_req_i   (req),
        .obi_rsp_o   (rsp),
        .reg_read_o  (rr),
        .reg_write_i (hw)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    obi_uart_rsp_buf_t exp_q[$];

    logic [7:0] m_rhr[NCH], m_thr[NCH], m_ier[NCH], m_fcr[NCH];
    logic [7:0] m_lcr[NCH], m_mcr[NCH], m_lsr[NCH], m_spr[NCH];
    logic [7:0] m_dll[NCH], m_dlm[NCH];
    logic [3:0] m_lvl[NCH], m_d[NCH];
    bit         m_rvalid;
    bit         g_last;

    string wmap0[8] = '{"THR", "IER", "FCR", "LCR", "MCR", "", "", "SPR"};
    string wmap1[8] = '{"DLL", "DLM", "FCR", "LCR", "MCR", "", "", "SPR"};
    string rmap0[8] = '{"RHR", "IER", "ISR", "LCR", "MCR", "LSR", "MSR", "SPR"};
    string rmap1[8] = '{"DLL", "DLM", "", "LCR", "MCR", "", "", "SPR"};

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_rhr[c] = 8'h00; m_thr[c] = 8'h00; m_ier[c] = 8'h00;
            m_fcr[c] = 8'h00; m_lcr[c] = 8'h00; m_mcr[c] = 8'h00;
            m_lsr[c] = 8'h60; m_spr[c] = 8'h00; m_dll[c] = 8'h00;
            m_dlm[c] = 8'h00; m_lvl[c] = 4'h0;  m_d[c]   = 4'h0;
        end
        m_rvalid = 0;
    endtask

    function automatic uart_reg_fields_t m_regs(int c);
        uart_reg_fields_t f;
        f.rhr = m_rhr[c]; f.thr = m_thr[c]; f.ier = m_ier[c];
        f.fcr = m_fcr[c]; f.lcr = m_lcr[c]; f.mcr = m_mcr[c];
        f.lsr = m_lsr[c]; f.msr = {m_lvl[c], m_d[c]}; f.spr = m_spr[c];
        f.dll = m_dll[c]; f.dlm = m_dlm[c];
        return f;
    endfunction

    function automatic logic [7:0] m_get(int c, string n);
        case (n)
            "RHR":   return m_rhr[c];
            "IER":   return m_ier[c];
            "ISR":   return hw[c].isr;
            "LCR":   return m_lcr[c];
            "MCR":   return m_mcr[c];
            "LSR":   return m_lsr[c];
            "MSR":   return {m_lvl[c], m_d[c]};
            "SPR":   return m_spr[c];
            "DLL":   return m_dll[c];
            "DLM":   return m_dlm[c];
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_set(int c, string n, logic [7:0] v);
        case (n)
            "THR":   m_thr[c] = v;
            "IER":   m_ier[c] = v;
            "FCR":   m_fcr[c] = v;
            "LCR":   m_lcr[c] = v;
            "MCR":   m_mcr[c] = v;
            "SPR":   m_spr[c] = v;
            "DLL":   m_dll[c] = v;
            "DLM":   m_dlm[c] = v;
            default: ;
        endcase
    endtask

    // One clock: inputs already driven; check, predict, advance model.
    task automatic step();
        int ch, ix;
        bit err, clr_msr, wr_ok;
        string nm;
        logic [7:0] rd;
        logic [5:0] pe[NCH];
        logic [3:0] ev;
        obi_uart_rsp_buf_t e;
        #4;
        check("rvalid", rsp.rvalid, m_rvalid);
        g_last = req.req && (!m_rvalid || req.rready);
        check("gnt", rsp.gnt, g_last);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("regs_ch%0d", c), rr[c].regs, m_regs(c));
            pe[c] = '0;
        end
        ch = int'(req.a.addr) / STRIDE;
        ix = (int'(req.a.addr) % STRIDE) / 4;
        nm = ""; err = 0; rd = 8'h00; clr_msr = 0; wr_ok = 0;
        if (g_last) begin
            if (ch >= NCH) begin
                err = 1;
            end else if (req.a.we) begin
                if (req.a.be[0]) begin
                    nm = m_lcr[ch][7] ? wmap1[ix] : wmap0[ix];
                    err = (nm == "");
                    wr_ok = !err;
                    if (nm == "THR") pe[ch][5] = 1;
                    if (nm == "DLL" || nm == "DLM") pe[ch][4] = 1;
                end
            end else begin
                nm = m_lcr[ch][7] ? rmap1[ix] : rmap0[ix];
                if (nm == "") err = 1;
                else rd = m_get(ch, nm);
                if (nm == "RHR") pe[ch][3] = 1;
                if (nm == "ISR") pe[ch][2] = 1;
                if (nm == "LSR") pe[ch][1] = 1;
                if (nm == "MSR") begin pe[ch][0] = 1; clr_msr = 1; end
            end
            e.rdata = {24'h0, rd};
            e.rid   = req.a.aid;
            e.err   = err;
            exp_q.push_back(e);
        end
        for (int c = 0; c < NCH; c++)
            check($sformatf("pulses_ch%0d", c),
                  {rr[c].obi_write_thr, rr[c].obi_write_dllm, rr[c].obi_read_rhr,
                   rr[c].obi_read_isr, rr[c].obi_read_lsr, rr[c].obi_read_msr}, pe[c]);
        for (int c = 0; c < NCH; c++) begin
            ev = {hw[c].modem.d_dcd, hw[c].modem.d_ri, hw[c].modem.d_dsr, hw[c].modem.d_cts};
            if (hw[c].rx.valid)    m_rhr[c] = hw[c].rx.data;
            if (hw[c].lsr.valid)   m_lsr[c] = hw[c].lsr.data;
            if (hw[c].modem.valid) m_lvl[c] = {hw[c].modem.dcd, hw[c].modem.ri,
                                               hw[c].modem.dsr, hw[c].modem.cts};
            m_d[c] = (clr_msr && c == ch) ? ev : (m_d[c] | ev);
        end
        if (wr_ok) m_set(ch, nm, req.a.wdata[7:0]);
        m_rvalid = g_last ? 1 : (req.rready ? 0 : m_rvalid);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        req.req = 0;
        repeat (n) step();
    endtask

    task automatic set_req(int ch, int idx, bit we, logic [7:0] d, logic [3:0] be);
        req.req     = 1;
        req.a.addr  = 32'(ch * STRIDE + idx * 4);
        req.a.we    = we;
        req.a.be    = be;
        req.a.wdata = $urandom;
        req.a.wdata[7:0] = d;
        req.a.aid   = 4'($urandom);
    endtask

    task automatic access(int ch, int idx, bit we, logic [7:0] d, logic [3:0] be = 4'hF);
        int n;
        n = 0;
        set_req(ch, idx, we, d, be);
        do begin
            step();
            n++;
        end while (!g_last && n < 20);
        if (!g_last) begin
            errors++;
            $display("FAIL grant_timeout: got no grant expected grant within 20 cycles");
        end
        req.req = 0;
    endtask

    task automatic do_reset();
        #1 rst = 1;
        #1;
        check("rst_rvalid", rsp.rvalid, 0);
        check("rst_rdata", rsp.r.rdata, 0);
        check("rst_rid", rsp.r.rid, 0);
        check("rst_err", rsp.r.err, 0);
        for (int c = 0; c < NCH; c++) begin
            check("rst_regs", rr[c].regs, RegResetVal);
            check("rst_pulses", {rr[c].obi_write_thr, rr[c].obi_write_dllm, rr[c].obi_read_rhr,
                                 rr[c].obi_read_isr, rr[c].obi_read_lsr, rr[c].obi_read_msr}, 0);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic rand_hw();
        for (int c = 0; c < NCH; c++) begin
            hw[c] = '0;
            hw[c].rx.valid    = ($urandom_range(0, 4) == 0);
            hw[c].rx.data     = 8'($urandom);
            hw[c].lsr.valid   = ($urandom_range(0, 9) == 0);
            hw[c].lsr.data    = 8'($urandom);
            hw[c].isr         = 8'($urandom);
            hw[c].modem.valid = ($urandom_range(0, 4) == 0);
            hw[c].modem.cts   = 1'($urandom);
            hw[c].modem.dsr   = 1'($urandom);
            hw[c].modem.ri    = 1'($urandom);
            hw[c].modem.dcd   = 1'($urandom);
            hw[c].modem.d_cts = ($urandom_range(0, 9) == 0);
            hw[c].modem.d_dsr = ($urandom_range(0, 9) == 0);
            hw[c].modem.d_ri  = ($urandom_range(0, 9) == 0);
            hw[c].modem.d_dcd = ($urandom_range(0, 9) == 0);
        end
    endtask

    // Response monitor: payload must match the oldest outstanding grant.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rsp.rvalid && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got rvalid expected no response");
                end else begin
                    check("rdata", rsp.r.rdata, exp_q[0].rdata);
                    check("rid", rsp.r.rid, exp_q[0].rid);
                    check("rsp_err", rsp.r.err, exp_q[0].err);
                    if (req.rready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend;
        req = '0;
        req.rready = 1;
        hw = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        idle(2);

        access(2, 3, 1, 8'h03);
        access(2, 3, 0, 8'h00);
        idle(1);

        access(1, 3, 1, 8'h80);
        access(1, 0, 1, 8'h1B);
        access(1, 1, 1, 8'h00);
        access(1, 0, 0, 8'h00);
        access(1, 5, 1, 8'h55);
        access(1, 2, 0, 8'h00);
        access(1, 3, 1, 8'h03);
        idle(1);

        req.rready = 0;
        access(0, 5, 0, 8'h00);
        set_req(0, 7, 0, 8'h00, 4'hF);
        repeat (3) step();
        req.rready = 1;
        step();
        idle(2);

        access(5, 3, 1, 8'h77);
        access(5, 3, 0, 8'h00);
        access(0, 3, 1, 8'h12, 4'h0);
        idle(1);

        hw[3].modem.d_cts = 1;
        idle(1);
        hw[3] = '0;
        access(3, 6, 0, 8'h00);
        hw[3].modem.d_cts = 1;
        access(3, 6, 0, 8'h00);
        hw[3] = '0;
        access(3, 6, 0, 8'h00);
        access(3, 6, 0, 8'h00);
        idle(1);

        req.rready = 0;
        access(2, 3, 0, 8'h00);
        set_req(1, 7, 0, 8'h00, 4'hF);
        step();
        do_reset();
        req.req = 0;
        req.rready = 1;
        idle(1);
        access(0, 7, 1, 8'hA5);
        access(0, 7, 0, 8'h00);
        idle(2);

        pend = 0;
        for (int i = 0; i < 400; i++) begin
            rand_hw();
            req.rready = ($urandom_range(0, 9) < 7);
            if (!pend) begin
                if ($urandom_range(0, 9) < 7)
                    set_req($urandom_range(0, 5), $urandom_range(0, 7), 1'($urandom),
                            8'($urandom), 4'($urandom));
                else
                    req.req = 0;
            end
            step();
            pend = req.req && !g_last;
        end

        hw = '0;
        req.rready = 1;
        idle(4);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
